// File: rtl/tcm_port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcm_port_arb_pkg
// Purpose  : Shared encodings for the TCM port arbiter: owner codes, FSM
//            state encoding, wait-counter ceiling and the tie-break helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tcm_port_arb_pkg;

    // Owner of the current or most recent grant
    localparam logic c_own_cpu = 1'b0;
    localparam logic c_own_ext = 1'b1;

    // Ceiling of the saturating CPU wait counter
    localparam logic [7:0] c_wait_max = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    // Winner of a tie when both requesters are valid in IDLE.
    // Round-robin hands the tie to whoever did not own the last grant;
    // otherwise EXT always wins.
    function automatic logic tie_to_ext(input logic last_owner, input logic rr_en);
        return rr_en ? (last_owner == c_own_cpu) : 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcm_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tcm_port_arb
// Purpose  : Two-requester (CPU / external loader) arbiter in front of one
//            single-port TCM RAM. Each access runs IDLE -> ISSUE -> RESP,
//            giving a 2-cycle grant-to-ready latency and 3 cycles per access.
// Config   : define TCM_ARB_RR_EN for round-robin tie-break; without it a
//            tie always goes to EXT.
// Ports    : clk, resetn (async assert, active-low)
//            cpu_valid/addr/wstrb/wdata -> cpu_ready/cpu_rdata
//            ext_valid/addr/wstrb/wdata -> ext_ready/ext_rdata
//            ram_cs/ram_wen/ram_addr/ram_wdata, ram_rdata (1-cycle read)
//            busy (not IDLE), owner (0=CPU,1=EXT), cpu_wait (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module tcm_port_arb
    import tcm_port_arb_pkg::*;
#(
    parameter int          AW   = 16,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          cpu_valid,
    input  logic [31:0]   cpu_addr,
    input  logic [3:0]    cpu_wstrb,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ready,
    output logic [31:0]   cpu_rdata,

    input  logic          ext_valid,
    input  logic [31:0]   ext_addr,
    input  logic [3:0]    ext_wstrb,
    input  logic [31:0]   ext_wdata,
    output logic          ext_ready,
    output logic [31:0]   ext_rdata,

    output logic          ram_cs,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,

    output logic          busy,
    output logic          owner,
    output logic [7:0]    cpu_wait
);

`ifdef TCM_ARB_RR_EN
    localparam logic c_rr_en = 1'b1;
`else
    localparam logic c_rr_en = 1'b0;
`endif

    arb_state_t    r_state;
    logic          r_owner;
    logic          r_cs;
    logic [3:0]    r_wen;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_cpu_ready;
    logic          r_ext_ready;
    logic          r_busy;
    logic [7:0]    r_cpu_wait;

    logic          w_req_any;
    logic          w_grant_ext;
    logic [31:0]   w_cpu_off;
    logic          w_cpu_active;
    logic          w_cpu_granted;
    logic          w_cpu_waiting;

    assign w_req_any   = cpu_valid | ext_valid;
    assign w_grant_ext = ext_valid & (~cpu_valid | tie_to_ext(r_owner, c_rr_en));
    // CPU addresses are region-relative; wrap below BASE is intentional
    assign w_cpu_off   = cpu_addr - BASE;

    // The CPU is not "waiting" while its own access is in flight, nor in the
    // IDLE cycle where it wins the grant.
    assign w_cpu_active  = (r_state != ST_IDLE) && (r_owner == c_own_cpu);
    assign w_cpu_granted = (r_state == ST_IDLE) && w_req_any && !w_grant_ext;
    assign w_cpu_waiting = cpu_valid && !w_cpu_active && !w_cpu_granted;

    generate
        if (AW < 32) begin : g_addr_unused
            logic w_unused_addr_bits;
            assign w_unused_addr_bits = ^{ext_addr[31:AW], w_cpu_off[31:AW]};
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_owner     <= c_own_ext;
            r_cs        <= 1'b0;
            r_wen       <= 4'h0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_cpu_ready <= 1'b0;
            r_ext_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_cpu_wait  <= 8'h00;
        end else begin
            if (w_cpu_waiting && (r_cpu_wait != c_wait_max)) begin
                r_cpu_wait <= r_cpu_wait + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        // Payload is captured here; later input changes are ignored
                        r_state <= ST_ISSUE;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b1;
                        r_owner <= w_grant_ext;
                        if (w_grant_ext) begin
                            r_wen   <= ext_wstrb;
                            r_addr  <= ext_addr[AW-1:0];
                            r_wdata <= ext_wdata;
                        end else begin
                            r_wen   <= cpu_wstrb;
                            r_addr  <= w_cpu_off[AW-1:0];
                            r_wdata <= cpu_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state     <= ST_RESP;
                    r_cs        <= 1'b0;
                    r_wen       <= 4'h0;
                    r_cpu_ready <= (r_owner == c_own_cpu);
                    r_ext_ready <= (r_owner == c_own_ext);
                end
                ST_RESP: begin
                    // Valid is deliberately not sampled in this cycle
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cpu_ready <= 1'b0;
                    r_ext_ready <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cs        <= 1'b0;
                    r_wen       <= 4'h0;
                    r_cpu_ready <= 1'b0;
                    r_ext_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ram_cs    = r_cs;
    assign ram_wen   = r_wen;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign cpu_wait  = r_cpu_wait;
    assign cpu_ready = r_cpu_ready;
    assign ext_ready = r_ext_ready;
    // RAM read data arrives in the RESP cycle and is steered to the owner only
    assign cpu_rdata = r_cpu_ready ? ram_rdata : 32'h0;
    assign ext_rdata = r_ext_ready ? ram_rdata : 32'h0;

endmodule
`default_nettype wire
